// File: rtl/clasificador_vc_pkg.sv
// -----------------------------------------------------------------------------
// clasificador_vc_pkg
//
// Purpose: shared definitions for the ingress VC classifier. It holds the word
// width, the index of the class bit, the FSM state encoding and the width of
// the optional statistics counters, plus a small wrapping-increment helper.
//
// Optional feature macro: CLASIF_CONTADORES_EN (statistics counters). The
// helper below is only used when that macro is defined.
// -----------------------------------------------------------------------------
package clasificador_vc_pkg;

  localparam int DATA_WIDTH = 6;  // word width
  localparam int VC_SEL_BIT = 5;  // class bit: 0 -> VC0, 1 -> VC1
  localparam int CNT_W      = 8;  // statistics counter width

  // Classifier FSM. The encoding is fixed because software and the
  // bench observe it directly.
  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAUSE  = 2'd3
  } estado_e;

  // Free-running counter step; wraps from all-ones back to zero.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

endpackage : clasificador_vc_pkg

// File: rtl/clasificador_vc_logica_push_vc.sv
// -----------------------------------------------------------------------------
// logica_push_vc
//
// Purpose: two-stage pop-to-push pipeline of the VC classifier. Stage 1 marks
// that the main FIFO was popped; stage 2 samples the word (which the main FIFO
// presents one cycle after the pop), routes it to VC0 or VC1 on the class bit,
// and either pushes it or flags a drop when the selected VC FIFO is full.
//
// Ports:
//   clk, reset_L        clock, asynchronous active-low reset
//   main_pop            pop strobe issued to the main FIFO this cycle
//   data_main           main FIFO read data (valid the cycle after main_pop)
//   full_VC0/full_VC1   VC FIFO full flags, checked at stage 2
//   VC0_push/VC1_push   registered push strobes (mutually exclusive)
//   data_VC0/data_VC1   registered push data; unselected side holds its value
//   drop_err            sticky drop flag, cleared only by reset
//   count_VC0/count_VC1/count_drop  wrapping statistics counters, present only
//                       when CLASIF_CONTADORES_EN is defined
// -----------------------------------------------------------------------------
module logica_push_vc #(
  parameter int DATA_WIDTH = clasificador_vc_pkg::DATA_WIDTH,
  parameter int VC_SEL_BIT = clasificador_vc_pkg::VC_SEL_BIT
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  main_pop,
  input  logic [DATA_WIDTH-1:0] data_main,
  input  logic                  full_VC0,
  input  logic                  full_VC1,
  output logic                  VC0_push,
  output logic                  VC1_push,
  output logic [DATA_WIDTH-1:0] data_VC0,
  output logic [DATA_WIDTH-1:0] data_VC1,
  output logic                  drop_err
`ifdef CLASIF_CONTADORES_EN
  ,
  output logic [clasificador_vc_pkg::CNT_W-1:0] count_VC0,
  output logic [clasificador_vc_pkg::CNT_W-1:0] count_VC1,
  output logic [clasificador_vc_pkg::CNT_W-1:0] count_drop
`endif
);
  import clasificador_vc_pkg::*;

  logic                  vld_p1_q;
  logic                  push0_p2_q;
  logic                  push1_p2_q;
  logic [DATA_WIDTH-1:0] data0_p2_q;
  logic [DATA_WIDTH-1:0] data1_p2_q;
  logic                  drop_q;

  logic                  sel_vc1;
  logic                  push0_d;
  logic                  push1_d;
  logic                  drop_d;

  // Stage-2 decision: data_main is only meaningful while vld_p1_q is set.
  always_comb begin
    sel_vc1 = data_main[VC_SEL_BIT];
    push0_d = vld_p1_q & ~sel_vc1 & ~full_VC0;
    push1_d = vld_p1_q &  sel_vc1 & ~full_VC1;
    drop_d  = vld_p1_q & ((~sel_vc1 & full_VC0) | (sel_vc1 & full_VC1));
  end

  // ---- stage 1: remember that a pop was issued ----
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= main_pop;
    end
  end

  // ---- stage 2: sample the popped word, demux it, push or drop ----
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push0_p2_q <= 1'b0;
      push1_p2_q <= 1'b0;
      data0_p2_q <= '0;
      data1_p2_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      push0_p2_q <= push0_d;
      push1_p2_q <= push1_d;
      if (push0_d) data0_p2_q <= data_main;
      if (push1_d) data1_p2_q <= data_main;
      if (drop_d)  drop_q     <= 1'b1;
    end
  end

`ifdef CLASIF_CONTADORES_EN
  logic [CNT_W-1:0] cnt_vc0_q;
  logic [CNT_W-1:0] cnt_vc1_q;
  logic [CNT_W-1:0] cnt_drop_q;

  // Counters advance on the same edge that registers the push or drop.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_vc0_q  <= '0;
      cnt_vc1_q  <= '0;
      cnt_drop_q <= '0;
    end else begin
      if (push0_d) cnt_vc0_q  <= cnt_inc(cnt_vc0_q);
      if (push1_d) cnt_vc1_q  <= cnt_inc(cnt_vc1_q);
      if (drop_d)  cnt_drop_q <= cnt_inc(cnt_drop_q);
    end
  end

  assign count_VC0  = cnt_vc0_q;
  assign count_VC1  = cnt_vc1_q;
  assign count_drop = cnt_drop_q;
`endif

  assign VC0_push = push0_p2_q;
  assign VC1_push = push1_p2_q;
  assign data_VC0 = data0_p2_q;
  assign data_VC1 = data1_p2_q;
  assign drop_err = drop_q;

endmodule : logica_push_vc

// File: rtl/clasificador_vc.sv
// -----------------------------------------------------------------------------
// clasificador_vc
//
// Purpose: ingress classifier. Drains the main input FIFO and writes each word
// into virtual-channel FIFO VC0 or VC1 according to its class bit, honouring
// the VC almost-full backpressure. The top level holds the control FSM and the
// main_pop request; the pop-to-push pipeline lives in logica_push_vc.
//
// Ports:
//   clk                 single clock, rising edge
//   reset_L             asynchronous active-low reset
//   data_main           main FIFO read data (valid the cycle after main_pop)
//   main_empty          main FIFO empty
//   almost_full_VC0/1   VC FIFO almost-full (leaves at least 2 free entries)
//   full_VC0/1          VC FIFO full
//   main_pop            pop request to the main FIFO
//   VC0_push/VC1_push   push strobes, never both high
//   data_VC0/data_VC1   registered push data
//   drop_err            sticky: a word was dropped because its VC was full
//   count_VC0/count_VC1/count_drop  8-bit wrapping counters, only when the
//                       macro CLASIF_CONTADORES_EN is defined
// -----------------------------------------------------------------------------
module clasificador_vc #(
  parameter int DATA_WIDTH = clasificador_vc_pkg::DATA_WIDTH,
  parameter int VC_SEL_BIT = clasificador_vc_pkg::VC_SEL_BIT
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_main,
  input  logic                  main_empty,
  input  logic                  almost_full_VC0,
  input  logic                  almost_full_VC1,
  input  logic                  full_VC0,
  input  logic                  full_VC1,
  output logic                  main_pop,
  output logic                  VC0_push,
  output logic                  VC1_push,
  output logic [DATA_WIDTH-1:0] data_VC0,
  output logic [DATA_WIDTH-1:0] data_VC1,
  output logic                  drop_err
`ifdef CLASIF_CONTADORES_EN
  ,
  output logic [clasificador_vc_pkg::CNT_W-1:0] count_VC0,
  output logic [clasificador_vc_pkg::CNT_W-1:0] count_VC1,
  output logic [clasificador_vc_pkg::CNT_W-1:0] count_drop
`endif
);
  import clasificador_vc_pkg::*;

  estado_e state_q;
  logic    af_any;

  // Either VC near full blocks popping: the target of the next word is not
  // known until it has been read, so both must have room.
  assign af_any = almost_full_VC0 | almost_full_VC1;

  // Control FSM. Leaving ACTIVE only stops new pops; words already in the
  // pipeline finish on their own.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (af_any)          state_q <= ST_PAUSE;
          else if (!main_empty) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (af_any)          state_q <= ST_PAUSE;
          else if (main_empty) state_q <= ST_IDLE;
        end
        ST_PAUSE: begin
          if (!af_any) state_q <= main_empty ? ST_IDLE : ST_ACTIVE;
        end
        default: begin
          state_q <= ST_RESET;
        end
      endcase
    end
  end

  // Gated combinationally so a rising almost_full or main_empty stops the
  // pop in the very same cycle, keeping in-flight words within the margin.
  assign main_pop = (state_q == ST_ACTIVE) & ~main_empty & ~af_any;

  logica_push_vc #(
    .DATA_WIDTH (DATA_WIDTH),
    .VC_SEL_BIT (VC_SEL_BIT)
  ) u_logica_push_vc (
    .clk        (clk),
    .reset_L    (reset_L),
    .main_pop   (main_pop),
    .data_main  (data_main),
    .full_VC0   (full_VC0),
    .full_VC1   (full_VC1),
    .VC0_push   (VC0_push),
    .VC1_push   (VC1_push),
    .data_VC0   (data_VC0),
    .data_VC1   (data_VC1),
    .drop_err   (drop_err)
`ifdef CLASIF_CONTADORES_EN
    ,
    .count_VC0  (count_VC0),
    .count_VC1  (count_VC1),
    .count_drop (count_drop)
`endif
  );

endmodule : clasificador_vc

// File: tb/tb_clasificador_vc.sv
// -----------------------------------------------------------------------------
// tb_clasificador_vc
//
// Directed bench for clasificador_vc. A small queue stands in for the main
// FIFO (one-cycle read latency); pushes seen on the VC outputs are collected
// and compared with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_clasificador_vc;

  logic       clk;
  logic       reset_L;
  logic [5:0] data_main;
  logic       main_empty;
  logic       almost_full_VC0;
  logic       almost_full_VC1;
  logic       full_VC0;
  logic       full_VC1;
  logic       main_pop;
  logic       VC0_push;
  logic       VC1_push;
  logic [5:0] data_VC0;
  logic [5:0] data_VC1;
  logic       drop_err;
`ifdef CLASIF_CONTADORES_EN
  logic [7:0] count_VC0;
  logic [7:0] count_VC1;
  logic [7:0] count_drop;
`endif

  int total;
  int bad;
  int npops;
  logic [5:0] fifo[$];
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] exp_q[$];

  clasificador_vc dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .data_main       (data_main),
    .main_empty      (main_empty),
    .almost_full_VC0 (almost_full_VC0),
    .almost_full_VC1 (almost_full_VC1),
    .full_VC0        (full_VC0),
    .full_VC1        (full_VC1),
    .main_pop        (main_pop),
    .VC0_push        (VC0_push),
    .VC1_push        (VC1_push),
    .data_VC0        (data_VC0),
    .data_VC1        (data_VC1),
    .drop_err        (drop_err)
`ifdef CLASIF_CONTADORES_EN
    ,
    .count_VC0       (count_VC0),
    .count_VC1       (count_VC1),
    .count_drop      (count_drop)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: model the main FIFO read (data valid the cycle after the pop)
  // and log any pushes. Outputs are examined 2 time units after the edge.
  task automatic tick();
    logic pop_s;
    pop_s = main_pop;
    @(posedge clk);
    #1;
    if (pop_s) begin
      if (fifo.size() > 0) data_main = fifo.pop_front();
      npops++;
    end
    main_empty = (fifo.size() == 0);
    #1;
    total++;
    if (VC0_push && VC1_push) begin bad++; $display("FAIL push_exclusive: VC0_push=%0b VC1_push=%0b required not both", VC0_push, VC1_push); end
    if (VC0_push) q0.push_back(data_VC0);
    if (VC1_push) q1.push_back(data_VC1);
  endtask

  task automatic clear_logs();
    q0.delete();
    q1.delete();
    npops = 0;
  endtask

  task automatic test_reset();
    reset_L = 1'b1;
    #3 reset_L = 1'b0;
    #1;
    total++; if (main_pop !== 1'b0) begin bad++; $display("FAIL rst_main_pop: got %0b want 0", main_pop); end
    total++; if (VC0_push !== 1'b0) begin bad++; $display("FAIL rst_vc0_push: got %0b want 0", VC0_push); end
    total++; if (VC1_push !== 1'b0) begin bad++; $display("FAIL rst_vc1_push: got %0b want 0", VC1_push); end
    total++; if (data_VC0 !== 6'h00) begin bad++; $display("FAIL rst_data_vc0: got %h want 00", data_VC0); end
    total++; if (data_VC1 !== 6'h00) begin bad++; $display("FAIL rst_data_vc1: got %h want 00", data_VC1); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL rst_drop_err: got %0b want 0", drop_err); end
    total++; if (dut.state_q !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dut.state_q); end
    repeat (2) tick();
    reset_L = 1'b1;
    tick();
    total++; if (dut.state_q !== 2'd1) begin bad++; $display("FAIL rst_to_idle: got %0d want 1", dut.state_q); end
    clear_logs();
  endtask

  task automatic test_basic();
    clear_logs();
    fifo.push_back(6'h05); fifo.push_back(6'h25); main_empty = 1'b0;
    #1;
    total++; if (main_pop !== 1'b0) begin bad++; $display("FAIL basic_pop_idle: got %0b want 0", main_pop); end
    tick();
    total++; if (main_pop !== 1'b1) begin bad++; $display("FAIL basic_pop1: got %0b want 1", main_pop); end
    tick();
    total++; if (main_pop !== 1'b1) begin bad++; $display("FAIL basic_pop2: got %0b want 1", main_pop); end
    total++; if (VC0_push !== 1'b0) begin bad++; $display("FAIL basic_early_push: got %0b want 0", VC0_push); end
    tick();
    total++; if (VC0_push !== 1'b1) begin bad++; $display("FAIL basic_vc0_push: got %0b want 1", VC0_push); end
    total++; if (data_VC0 !== 6'h05) begin bad++; $display("FAIL basic_vc0_data: got %h want 05", data_VC0); end
    total++; if (main_pop !== 1'b0) begin bad++; $display("FAIL basic_pop_stop: got %0b want 0", main_pop); end
    tick();
    total++; if (VC1_push !== 1'b1) begin bad++; $display("FAIL basic_vc1_push: got %0b want 1", VC1_push); end
    total++; if (data_VC1 !== 6'h25) begin bad++; $display("FAIL basic_vc1_data: got %h want 25", data_VC1); end
    total++; if (VC0_push !== 1'b0) begin bad++; $display("FAIL basic_vc0_off: got %0b want 0", VC0_push); end
    total++; if (data_VC0 !== 6'h05) begin bad++; $display("FAIL basic_vc0_hold: got %h want 05", data_VC0); end
    repeat (3) tick();
    total++; if (npops !== 2) begin bad++; $display("FAIL basic_npops: got %0d want 2", npops); end
    total++; if (q0.size() !== 1 || q1.size() !== 1) begin bad++; $display("FAIL basic_push_count: got %0d/%0d want 1/1", q0.size(), q1.size()); end
    total++; if (dut.state_q !== 2'd1) begin bad++; $display("FAIL basic_state: got %0d want 1", dut.state_q); end
  endtask

  task automatic test_almost_full();
    clear_logs();
    exp_q = '{6'h21, 6'h22, 6'h23, 6'h24};
    foreach (exp_q[i]) fifo.push_back(exp_q[i]);
    main_empty = 1'b0;
    #1;
    tick(); tick(); tick();
    almost_full_VC1 = 1'b1;
    #1;
    total++; if (main_pop !== 1'b0) begin bad++; $display("FAIL af_pop_same_cycle: got %0b want 0", main_pop); end
    tick();
    total++; if (dut.state_q !== 2'd3) begin bad++; $display("FAIL af_state_pause: got %0d want 3", dut.state_q); end
    total++; if (VC1_push !== 1'b1 || data_VC1 !== 6'h22) begin bad++; $display("FAIL af_inflight_push: got %0b/%h want 1/22", VC1_push, data_VC1); end
    tick(); tick();
    total++; if (q1.size() !== 2 || npops !== 2) begin bad++; $display("FAIL af_paused_count: got pushes=%0d pops=%0d want 2/2", q1.size(), npops); end
    total++; if (main_pop !== 1'b0) begin bad++; $display("FAIL af_pause_pop: got %0b want 0", main_pop); end
    almost_full_VC1 = 1'b0;
    #1;
    total++; if (main_pop !== 1'b0) begin bad++; $display("FAIL af_clear_pop: got %0b want 0", main_pop); end
    tick();
    total++; if (main_pop !== 1'b1) begin bad++; $display("FAIL af_resume_pop: got %0b want 1", main_pop); end
    repeat (5) tick();
    total++; if (npops !== 4 || q0.size() !== 0) begin bad++; $display("FAIL af_totals: got pops=%0d vc0=%0d want 4/0", npops, q0.size()); end
    total++; if (q1.size() !== 4) begin bad++; $display("FAIL af_vc1_count: got %0d want 4", q1.size()); end
    else foreach (exp_q[i]) begin
      total++; if (q1[i] !== exp_q[i]) begin bad++; $display("FAIL af_vc1_word%0d: got %h want %h", i, q1[i], exp_q[i]); end
    end
    total++; if (dut.state_q !== 2'd1) begin bad++; $display("FAIL af_state_idle: got %0d want 1", dut.state_q); end
  endtask

  task automatic test_pause_exit();
    almost_full_VC0 = 1'b1; almost_full_VC1 = 1'b1;
    tick();
    total++; if (dut.state_q !== 2'd3) begin bad++; $display("FAIL pex_pause: got %0d want 3", dut.state_q); end
    almost_full_VC0 = 1'b0; almost_full_VC1 = 1'b0;
    tick();
    total++; if (dut.state_q !== 2'd1) begin bad++; $display("FAIL pex_idle: got %0d want 1", dut.state_q); end
  endtask

  task automatic test_empty_mid();
    clear_logs();
    exp_q = '{6'h01, 6'h02, 6'h03};
    foreach (exp_q[i]) fifo.push_back(exp_q[i]);
    main_empty = 1'b0;
    #1;
    repeat (4) tick();
    total++; if (main_pop !== 1'b0) begin bad++; $display("FAIL em_pop_stop: got %0b want 0", main_pop); end
    repeat (4) tick();
    total++; if (npops !== 3 || q1.size() !== 0) begin bad++; $display("FAIL em_totals: got pops=%0d vc1=%0d want 3/0", npops, q1.size()); end
    total++; if (q0.size() !== 3) begin bad++; $display("FAIL em_vc0_count: got %0d want 3", q0.size()); end
    else foreach (exp_q[i]) begin
      total++; if (q0[i] !== exp_q[i]) begin bad++; $display("FAIL em_vc0_word%0d: got %h want %h", i, q0[i], exp_q[i]); end
    end
    total++; if (dut.state_q !== 2'd1) begin bad++; $display("FAIL em_state_idle: got %0d want 1", dut.state_q); end
  endtask

  task automatic test_drop();
    clear_logs();
    full_VC0 = 1'b1;
    fifo.push_back(6'h0A); main_empty = 1'b0;
    #1;
    tick(); tick();
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL drop_early: got %0b want 0", drop_err); end
    tick();
    total++; if (VC0_push !== 1'b0) begin bad++; $display("FAIL drop_no_push: got %0b want 0", VC0_push); end
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL drop_set: got %0b want 1", drop_err); end
    total++; if (data_VC0 !== 6'h03) begin bad++; $display("FAIL drop_data_hold: got %h want 03", data_VC0); end
    full_VC0 = 1'b0;
    repeat (3) tick();
    total++; if (drop_err !== 1'b1 || q0.size() !== 0) begin bad++; $display("FAIL drop_sticky: got %0b/%0d want 1/0", drop_err, q0.size()); end
    fifo.push_back(6'h0B); main_empty = 1'b0;
    #1;
    repeat (6) tick();
    total++; if (q0.size() !== 1 || data_VC0 !== 6'h0B) begin bad++; $display("FAIL drop_next_push: got %0d/%h want 1/0b", q0.size(), data_VC0); end
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL drop_still_set: got %0b want 1", drop_err); end
`ifdef CLASIF_CONTADORES_EN
    total++; if (count_drop !== 8'd1) begin bad++; $display("FAIL drop_count: got %0d want 1", count_drop); end
`endif
  endtask

  task automatic test_reset_inflight();
    clear_logs();
    fifo.push_back(6'h11); fifo.push_back(6'h31); fifo.push_back(6'h12);
    main_empty = 1'b0;
    #1;
    tick(); tick();
    reset_L = 1'b0;
    #1;
    total++; if (main_pop !== 1'b0 || VC0_push !== 1'b0 || VC1_push !== 1'b0) begin bad++; $display("FAIL rif_ctrl: got pop=%0b p0=%0b p1=%0b want 0/0/0", main_pop, VC0_push, VC1_push); end
    total++; if (data_VC0 !== 6'h00 || data_VC1 !== 6'h00) begin bad++; $display("FAIL rif_data: got %h/%h want 00/00", data_VC0, data_VC1); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL rif_drop_clr: got %0b want 0", drop_err); end
    total++; if (dut.state_q !== 2'd0) begin bad++; $display("FAIL rif_state: got %0d want 0", dut.state_q); end
    reset_L = 1'b1;
    repeat (3) tick();
    total++; if (q0.size() + q1.size() !== 0) begin bad++; $display("FAIL rif_no_push: got %0d want 0", q0.size() + q1.size()); end
    repeat (5) tick();
    total++; if (q1.size() !== 1 || q0.size() !== 1) begin bad++; $display("FAIL rif_counts: got %0d/%0d want 1/1", q0.size(), q1.size()); end
    else begin
      total++; if (q1[0] !== 6'h31) begin bad++; $display("FAIL rif_vc1_word: got %h want 31", q1[0]); end
      total++; if (q0[0] !== 6'h12) begin bad++; $display("FAIL rif_vc0_word: got %h want 12", q0[0]); end
    end
  endtask

`ifdef CLASIF_CONTADORES_EN
  task automatic test_counter_wrap();
    clear_logs();
    reset_L = 1'b0;
    #1 reset_L = 1'b1;
    for (int i = 0; i < 256; i++) fifo.push_back(6'(i % 32));
    main_empty = 1'b0;
    #1;
    repeat (266) tick();
    total++; if (q0.size() !== 256) begin bad++; $display("FAIL wrap_pushes: got %0d want 256", q0.size()); end
    total++; if (count_VC0 !== 8'd0) begin bad++; $display("FAIL wrap_count_vc0: got %0d want 0", count_VC0); end
    total++; if (count_VC1 !== 8'd0) begin bad++; $display("FAIL wrap_count_vc1: got %0d want 0", count_VC1); end
  endtask
`endif

  initial begin
    total = 0; bad = 0; npops = 0;
    data_main = 6'h00; main_empty = 1'b1;
    almost_full_VC0 = 1'b0; almost_full_VC1 = 1'b0;
    full_VC0 = 1'b0; full_VC1 = 1'b0;
    reset_L = 1'b1;
    test_reset();
    test_basic();
    test_almost_full();
    test_pause_exit();
    test_empty_mid();
    test_drop();
    test_reset_inflight();
`ifdef CLASIF_CONTADORES_EN
    test_counter_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_clasificador_vc
